// File: rtl/riscv_memarbiter.sv
// Purpose : arbitrates one shared memory port among data (0), fetch (1) and page walker (2).
// Latency : request sampled in cycle t gives a registered grant in t+1; back-to-back grants on memack.
// Backpressure: a grant is held until memack; losers keep requesting and age toward an override.
//
// Ports
//   i_riscv_arb_clk     clock, rising edge
//   i_riscv_arb_rst     synchronous active-high reset
//   i_riscv_arb_req     [2:0] per-requester request, held until its done pulse
//   i_riscv_arb_memack  one-cycle completion pulse from memory
//   o_riscv_arb_gnt     [2:0] registered one-hot grant, 000 when idle
//   o_riscv_arb_sel     [1:0] mux select, 11 = none
//   o_riscv_arb_memreq  registered memory request valid (= |gnt)
//   o_riscv_arb_done    [2:0] combinational completion = gnt & memack
//   o_riscv_arb_busy    high while a transaction is in flight
module riscv_memarbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic       i_riscv_arb_clk,
    input  logic       i_riscv_arb_rst,
    input  logic [2:0] i_riscv_arb_req,
    input  logic       i_riscv_arb_memack,
    output logic [2:0] o_riscv_arb_gnt,
    output logic [1:0] o_riscv_arb_sel,
    output logic       o_riscv_arb_memreq,
    output logic [2:0] o_riscv_arb_done,
    output logic       o_riscv_arb_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       gnt;
    logic [2:0]       gnt_nxt;
    logic [1:0]       sel;
    logic [1:0]       sel_nxt;
    logic             memreq;
    logic [CNT_W-1:0] age     [3];
    logic [CNT_W-1:0] age_nxt [3];

    logic [2:0]       elig;
    logic [2:0]       starved;
    logic             win_vld;
    logic [1:0]       win_idx;

    // Arbitration only happens when idle or when the current transaction
    // completes; the finishing requester is masked so that a still-high
    // req cannot immediately re-win its own slot.
    always_comb begin
        elig = 3'b000;
        if (state == IDLE) begin
            elig = i_riscv_arb_req;
        end else if (i_riscv_arb_memack) begin
            elig = i_riscv_arb_req & ~gnt;
        end

        for (int i = 0; i < 3; i++) begin
            starved[i] = elig[i] && (age[i] == LIMIT);
        end

        win_vld = |elig;
        win_idx = 2'd0;
        // Starved requesters pre-empt fixed priority; ties go to the lower index.
        if (starved[0])      win_idx = 2'd0;
        else if (starved[1]) win_idx = 2'd1;
        else if (starved[2]) win_idx = 2'd2;
        else if (elig[0])    win_idx = 2'd0;
        else if (elig[1])    win_idx = 2'd1;
        else if (elig[2])    win_idx = 2'd2;
    end

    // Next state / next grant.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        if (win_vld) begin
            state_nxt = BUSY;
            gnt_nxt   = 3'b001 << win_idx;
            sel_nxt   = win_idx;
        end else if (state == BUSY && i_riscv_arb_memack) begin
            state_nxt = IDLE;
            gnt_nxt   = 3'b000;
            sel_nxt   = 2'b11;
        end
    end

    // Age counters: winner clears, waiting requester counts up (saturating),
    // an idle requester clears; a granted requester holds (already zero).
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            age_nxt[i] = age[i];
            if (win_vld && win_idx == 2'(i)) begin
                age_nxt[i] = '0;
            end else if (i_riscv_arb_req[i] && !gnt[i]) begin
                if (age[i] != LIMIT) begin
                    age_nxt[i] = age[i] + ONE;
                end
            end else if (!i_riscv_arb_req[i]) begin
                age_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge i_riscv_arb_clk) begin
        if (i_riscv_arb_rst) begin
            state  <= IDLE;
            gnt    <= 3'b000;
            sel    <= 2'b11;
            memreq <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                age[i] <= '0;
            end
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            sel    <= sel_nxt;
            memreq <= |gnt_nxt;
            for (int i = 0; i < 3; i++) begin
                age[i] <= age_nxt[i];
            end
        end
    end

    assign o_riscv_arb_gnt    = gnt;
    assign o_riscv_arb_sel    = sel;
    assign o_riscv_arb_memreq = memreq;
    assign o_riscv_arb_done   = gnt & {3{i_riscv_arb_memack}};
    assign o_riscv_arb_busy   = (state == BUSY);

endmodule

// File: tb/tb_riscv_memarbiter.sv
// Purpose : directed self-checking bench for riscv_memarbiter.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled on the falling edge.
// Backpressure: memack is driven directly by the stimulus sequence.
module tb_riscv_memarbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       memack;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       memreq;
    logic [2:0] done;
    logic       busy;

    int checks;
    int failures;

    riscv_memarbiter #(
        .STARVE_LIMIT(8),
        .CNT_W       (4)
    ) dut (
        .i_riscv_arb_clk   (clk),
        .i_riscv_arb_rst   (rst),
        .i_riscv_arb_req   (req),
        .i_riscv_arb_memack(memack),
        .o_riscv_arb_gnt   (gnt),
        .o_riscv_arb_sel   (sel),
        .o_riscv_arb_memreq(memreq),
        .o_riscv_arb_done  (done),
        .o_riscv_arb_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: drive inputs after the edge, sample at the falling
    // edge, and check the structural invariants on every cycle.
    task automatic cyc(input logic [2:0] r, input logic a, input logic rs);
        @(posedge clk);
        #1;
        req    = r;
        memack = a;
        rst    = rs;
        @(negedge clk);
        chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
        chk("inv_sel",    32'((sel == 2'b11) == (gnt == 3'b000)), 32'd1);
        chk("inv_memreq", 32'(memreq), 32'(|gnt));
        chk("inv_done",   32'(done & ~gnt), 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic [2:0] g, input logic [1:0] s,
                              input logic [2:0] d, input logic b);
        chk({tag, "_gnt"},    32'(gnt),    32'(g));
        chk({tag, "_sel"},    32'(sel),    32'(s));
        chk({tag, "_memreq"}, 32'(memreq), 32'(|g));
        chk({tag, "_done"},   32'(done),   32'(d));
        chk({tag, "_busy"},   32'(busy),   32'(b));
    endtask

    initial begin
        logic [2:0] starve_seq [10];
        checks   = 0;
        failures = 0;
        req      = 3'b111;
        memack   = 1'b0;
        rst      = 1'b1;

        // 1. Reset held two cycles with all requests high.
        cyc(3'b111, 1'b0, 1'b1);
        expect_out("rst_a", 3'b000, 2'b11, 3'b000, 1'b0);
        cyc(3'b111, 1'b0, 1'b1);
        expect_out("rst_b", 3'b000, 2'b11, 3'b000, 1'b0);
        cyc(3'b111, 1'b0, 1'b0);
        expect_out("rst_rel", 3'b000, 2'b11, 3'b000, 1'b0);
        cyc(3'b111, 1'b0, 1'b0);
        expect_out("rst_first", 3'b001, 2'b00, 3'b000, 1'b1);
        cyc(3'b000, 1'b0, 1'b1);

        // 2. Single fetch, memack three cycles after the request.
        cyc(3'b010, 1'b0, 1'b0);
        expect_out("f_t0", 3'b000, 2'b11, 3'b000, 1'b0);
        cyc(3'b010, 1'b0, 1'b0);
        expect_out("f_t1", 3'b010, 2'b01, 3'b000, 1'b1);
        cyc(3'b010, 1'b0, 1'b0);
        expect_out("f_t2", 3'b010, 2'b01, 3'b000, 1'b1);
        cyc(3'b010, 1'b1, 1'b0);
        expect_out("f_t3", 3'b010, 2'b01, 3'b010, 1'b1);
        cyc(3'b000, 1'b0, 1'b0);
        expect_out("f_t4", 3'b000, 2'b11, 3'b000, 1'b0);

        // 3. Back-to-back grants, data returns after fetch.
        cyc(3'b011, 1'b0, 1'b0);
        expect_out("b2b_c0", 3'b000, 2'b11, 3'b000, 1'b0);
        cyc(3'b011, 1'b1, 1'b0);
        expect_out("b2b_c1", 3'b001, 2'b00, 3'b001, 1'b1);
        cyc(3'b011, 1'b1, 1'b0);
        expect_out("b2b_c2", 3'b010, 2'b01, 3'b010, 1'b1);
        cyc(3'b000, 1'b1, 1'b0);
        expect_out("b2b_c3", 3'b001, 2'b00, 3'b001, 1'b1);
        cyc(3'b000, 1'b0, 1'b0);
        expect_out("b2b_c4", 3'b000, 2'b11, 3'b000, 1'b0);

        // 4. Starvation: data and fetch alternate while the walker ages to 8.
        starve_seq = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001,
                       3'b010, 3'b001, 3'b010, 3'b100, 3'b001};
        cyc(3'b111, 1'b0, 1'b0);
        expect_out("st_c0", 3'b000, 2'b11, 3'b000, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(3'b111, 1'b1, 1'b0);
            chk($sformatf("st_gnt_c%0d", k + 1), 32'(gnt), 32'(starve_seq[k]));
            chk($sformatf("st_done_c%0d", k + 1), 32'(done), 32'(starve_seq[k]));
            if (k == 7) chk("st_age2_sat", 32'(dut.age[2]), 32'd8);
            if (k == 8) chk("st_age2_clr", 32'(dut.age[2]), 32'd0);
        end
        cyc(3'b000, 1'b1, 1'b0);
        expect_out("st_c11", 3'b010, 2'b01, 3'b010, 1'b1);
        cyc(3'b000, 1'b0, 1'b0);
        expect_out("st_c12", 3'b000, 2'b11, 3'b000, 1'b0);

        // 5. Early request drop; then memack while idle must be ignored.
        cyc(3'b001, 1'b0, 1'b0);
        expect_out("ed_c0", 3'b000, 2'b11, 3'b000, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);
        expect_out("ed_c1", 3'b001, 2'b00, 3'b000, 1'b1);
        cyc(3'b000, 1'b0, 1'b0);
        expect_out("ed_c2", 3'b001, 2'b00, 3'b000, 1'b1);
        cyc(3'b000, 1'b1, 1'b0);
        expect_out("ed_c3", 3'b001, 2'b00, 3'b001, 1'b1);
        cyc(3'b000, 1'b0, 1'b0);
        expect_out("ed_c4", 3'b000, 2'b11, 3'b000, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        expect_out("idle_ack", 3'b000, 2'b11, 3'b000, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);
        expect_out("idle_ack_after", 3'b000, 2'b11, 3'b000, 1'b0);

        // 6. Reset while busy with the walker aging.
        cyc(3'b101, 1'b0, 1'b0);
        expect_out("mr_c0", 3'b000, 2'b11, 3'b000, 1'b0);
        cyc(3'b101, 1'b0, 1'b0);
        expect_out("mr_c1", 3'b001, 2'b00, 3'b000, 1'b1);
        cyc(3'b101, 1'b0, 1'b0);
        chk("mr_age2_pre", 32'(dut.age[2]), 32'd2);
        cyc(3'b101, 1'b0, 1'b1);
        expect_out("mr_c3", 3'b001, 2'b00, 3'b000, 1'b1);
        cyc(3'b101, 1'b1, 1'b0);
        expect_out("mr_c4", 3'b000, 2'b11, 3'b000, 1'b0);
        chk("mr_age0", 32'(dut.age[0]), 32'd0);
        chk("mr_age1", 32'(dut.age[1]), 32'd0);
        chk("mr_age2", 32'(dut.age[2]), 32'd0);
        cyc(3'b000, 1'b0, 1'b0);
        expect_out("mr_c5", 3'b001, 2'b00, 3'b000, 1'b1);
        cyc(3'b000, 1'b1, 1'b0);
        expect_out("mr_c6", 3'b001, 2'b00, 3'b001, 1'b1);
        cyc(3'b000, 1'b0, 1'b0);
        expect_out("mr_c7", 3'b000, 2'b11, 3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
